// File: rtl/concat_packer_pkg.sv
// Shared types and widths for the concat_packer byte-to-word packer.
package concat_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    PACK4 = 2'd0,
    REP4  = 2'd1,
    PAIR  = 2'd2,
    RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FIRST   = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/concat_packer_if.sv
// Byte-in / word-out handshake bundle; the packer sits on the slave modport.
interface concat_packer_if;
  import concat_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic [1:0]        in_mode;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [2:0]        out_count;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_err
  );

endinterface

// File: rtl/concat_lane_fill.sv
// Combinational lane mapper: turns captured bytes, mode and byte count into the output word.
module concat_lane_fill
  import concat_pkg::*;
(
  input  mode_e             mode,
  input  logic [WORD_W-1:0] bytes,
  input  logic [2:0]        count,
  input  logic [BYTE_W-1:0] pad,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_W-1:0] b1;
  logic [BYTE_W-1:0] b0;

  assign b1 = bytes[WORD_W-1 -: BYTE_W];
  assign b0 = bytes[WORD_W-1-BYTE_W -: BYTE_W];

  always_comb begin
    // NOTE: default assignment first so every path drives word and no latch is inferred.
    word = '0;
    unique case (mode)
      PACK4: begin
        for (int k = 0; k < WORD_BYTES; k++) begin
          word[WORD_W-1-k*BYTE_W -: BYTE_W] =
            (3'(k) < count) ? bytes[WORD_W-1-k*BYTE_W -: BYTE_W] : pad;
        end
      end
      REP4, RSVD: word = {WORD_BYTES{b1}};
      PAIR:       word = (count == 3'd1) ? {2{b1, pad}} : {2{b1, b0}};
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/concat_packer.sv
// Byte packer top: FSM, partial-word capture and output handshake.
// HOLD means a finished word is waiting and nothing new is in progress; it accepts first bytes like FIRST.
module concat_packer
  import concat_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = 8'h00
) (
  input logic            clk,
  input logic            rst_n,
  concat_packer_if.slave bus
);

  state_e            state;
  mode_e             mode_q;
  logic [2:0]        idx;
  logic [WORD_W-1:0] partial;
  logic [WORD_W-1:0] word_q;
  logic [2:0]        count_q;
  logic              err_q;

  logic              in_ready;
  logic              accept;
  logic              take;
  logic              first;
  mode_e             cur_mode;
  logic [1:0]        lane;
  logic [2:0]        new_count;
  logic [WORD_W-1:0] merged;
  logic              ends_word;
  logic              complete;
  logic [WORD_W-1:0] fill_word;

  assign in_ready      = (state != HOLD) || bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_word  = word_q;
  assign bus.out_count = count_q;
  assign bus.out_err   = err_q;

  assign accept    = bus.in_valid && in_ready;
  assign take      = (state == HOLD) && bus.out_ready;
  assign first     = (state != COLLECT);
  assign cur_mode  = first ? mode_e'(bus.in_mode) : mode_q;
  assign lane      = first ? 2'd0 : idx[1:0];
  assign new_count = first ? 3'd1 : idx + 3'd1;

  always_comb begin
    merged = first ? '0 : partial;
    merged[WORD_W-1-int'(lane)*BYTE_W -: BYTE_W] = bus.in_data;
  end

  always_comb begin
    ends_word = 1'b0;
    unique case (cur_mode)
      PACK4:      ends_word = bus.in_last || (new_count == 3'(WORD_BYTES));
      REP4, RSVD: ends_word = 1'b1;
      PAIR:       ends_word = bus.in_last || (new_count == 3'd2);
      default:    ends_word = 1'b1;
    endcase
  end

  assign complete = accept && ends_word;

  concat_lane_fill u_lane_fill (
    .mode  (cur_mode),
    .bytes (merged),
    .count (new_count),
    .pad   (PAD_BYTE),
    .word  (fill_word)
  );

  // NOTE: every register here is control or a single word, so all of it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FIRST;
      mode_q  <= PACK4;
      idx     <= '0;
      partial <= '0;
      word_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (complete) begin
      // NOTE: non-blocking so every flop samples the pre-edge values regardless of statement order.
      state   <= HOLD;
      idx     <= '0;
      partial <= '0;
      word_q  <= fill_word;
      count_q <= new_count;
      err_q   <= (cur_mode == RSVD);
    end else if (accept) begin
      state   <= COLLECT;
      idx     <= new_count;
      partial <= merged;
      if (first) mode_q <= cur_mode;
    end else if (take) begin
      state <= FIRST;
    end
  end

endmodule

// File: tb/tb_concat_packer.sv
// Directed self-checking bench for concat_packer with hand-computed expected words.
module tb_concat_packer;
  import concat_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  concat_packer_if bus_if ();

  concat_packer #(.PAD_BYTE(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] word, input logic [2:0] cnt,
                            input logic err);
    check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({tag, "_word"},  bus_if.out_word, word);
    check({tag, "_count"}, 32'(bus_if.out_count), 32'(cnt));
    check({tag, "_err"},   32'(bus_if.out_err), 32'(err));
  endtask

  // Presents one byte, waits (bounded) for in_ready, returns just after the accepting edge.
  task automatic push(input logic [7:0] d, input logic [1:0] m, input logic l);
    int n;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_mode  = m;
    bus_if.in_last  = l;
    #1;
    n = 0;
    while (!bus_if.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) check("push_timeout", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_if.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_mode   = '0;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b1;
    #1;
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_word",  bus_if.out_word, 32'h0);
    check("rst_count", 32'(bus_if.out_count), 32'd0);
    check("rst_err",   32'(bus_if.out_err), 32'd0);
    check("rst_ready", 32'(bus_if.in_ready), 32'd1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(bus_if.in_ready), 32'd1);

    // PACK4 full word, latency 1 after the 4th byte
    push(8'hAA, 2'd0, 1'b0);
    push(8'h55, 2'd0, 1'b0);
    push(8'h12, 2'd0, 1'b0);
    check("pack4_not_yet", 32'(bus_if.out_valid), 32'd0);
    push(8'h34, 2'd0, 1'b0);
    check_word("pack4", 32'hAA551234, 3'd4, 1'b0);
    idle(1);
    check("pack4_drop", 32'(bus_if.out_valid), 32'd0);

    // REP4 then PAIR, issued without idle cycles
    push(8'hAA, 2'd1, 1'b1);
    check_word("rep4", 32'hAAAAAAAA, 3'd1, 1'b0);
    push(8'hAA, 2'd2, 1'b0);
    check("pair_mid_valid", 32'(bus_if.out_valid), 32'd0);
    push(8'h55, 2'd0, 1'b0);
    check_word("pair", 32'hAA55AA55, 3'd2, 1'b0);

    // take and completion in the same cycle keep out_valid high
    push(8'h11, 2'd1, 1'b0);
    check_word("rep4_a", 32'h11111111, 3'd1, 1'b0);
    push(8'h22, 2'd1, 1'b0);
    check_word("rep4_b", 32'h22222222, 3'd1, 1'b0);
    idle(1);

    // short PACK4 padded with PAD_BYTE
    push(8'hAA, 2'd0, 1'b0);
    push(8'h55, 2'd0, 1'b1);
    check_word("pack4_short", 32'hAA550000, 3'd2, 1'b0);
    idle(1);

    // PAIR closed on its first byte
    push(8'h9C, 2'd2, 1'b1);
    check_word("pair_short", 32'h9C009C00, 3'd1, 1'b0);
    idle(1);

    // backpressure: 5 stalled cycles with a byte waiting
    bus_if.out_ready = 1'b0;
    push(8'h77, 2'd1, 1'b0);
    check_word("stall_word", 32'h77777777, 3'd1, 1'b0);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h01;
    bus_if.in_mode  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
      check("stall_hold_word", bus_if.out_word, 32'h77777777);
      check("stall_hold_valid", 32'(bus_if.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    push(8'h01, 2'd0, 1'b0);
    check("release_drop", 32'(bus_if.out_valid), 32'd0);
    push(8'h02, 2'd0, 1'b0);
    push(8'h03, 2'd0, 1'b0);
    push(8'h04, 2'd0, 1'b0);
    check_word("after_stall", 32'h01020304, 3'd4, 1'b0);
    idle(1);

    // reserved mode flags error, not sticky
    push(8'h5A, 2'd3, 1'b0);
    check_word("rsvd", 32'h5A5A5A5A, 3'd1, 1'b1);
    push(8'h3C, 2'd1, 1'b0);
    check_word("rep4_after_rsvd", 32'h3C3C3C3C, 3'd1, 1'b0);
    idle(1);

    // reset mid-word discards the partial bytes
    push(8'h11, 2'd0, 1'b0);
    push(8'h22, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst_word",  bus_if.out_word, 32'h0);
    check("midrst_ready", 32'(bus_if.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'hDE, 2'd0, 1'b0);
    push(8'hAD, 2'd1, 1'b0);
    push(8'hBE, 2'd3, 1'b0);
    check("deadbeef_not_yet", 32'(bus_if.out_valid), 32'd0);
    push(8'hEF, 2'd2, 1'b1);
    check_word("deadbeef", 32'hDEADBEEF, 3'd4, 1'b0);
    idle(1);
    check("final_drop", 32'(bus_if.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
